// File: rtl/fpc_arbiter.sv
// ============================================================================
// Module   : fpc_arbiter
// Purpose  : Two-port round-robin request arbiter/sequencer for the shared
//            bfloat16 Fpc, with result routing back to the issuing port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpc_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_mode,
    input  logic [1:0][15:0] req_a,
    input  logic [1:0][15:0] req_b,
    output logic [1:0]       rsp_valid,
    output logic [15:0]      rsp_data,
    output logic             fpc_rst_n,
    output logic             fpc_in_valid,
    output logic             fpc_mode,
    output logic [15:0]      fpc_in_a,
    output logic [15:0]      fpc_in_b,
    input  logic             fpc_out_valid,
    input  logic [15:0]      fpc_out,
    output logic             busy
);

    localparam int             AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [1:0]         ne;
    logic [1:0]         push;
    logic [1:0]         pop;
    logic [1:0][32:0]   head;
    logic [1:0][CW-1:0] count;

    logic               grant;
    logic               gport;
    logic               last_grant;
    logic               tag_v;
    logic               tag;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [32:0]   mem [DEPTH];
            logic [AW-1:0] wr_ptr;
            logic [AW-1:0] rd_ptr;
            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (push[p]) begin
                    mem[wr_ptr] <= {req_mode[p], req_a[p], req_b[p]};
                end
            end

            // Power-of-two depth lets the pointers wrap naturally.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (push[p]) begin
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                    if (pop[p]) begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                    case ({push[p], pop[p]})
                        2'b10:   cnt <= cnt + CW'(1);
                        2'b01:   cnt <= cnt - CW'(1);
                        default: cnt <= cnt;
                    endcase
                end
            end

            assign ne[p]        = (cnt != '0);
            assign head[p]      = mem[rd_ptr];
            assign count[p]     = cnt;
            assign req_ready[p] = !rst && (cnt != FULL);
            assign push[p]      = req_valid[p] && req_ready[p];
        end
    endgenerate

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant = ne[0] || ne[1];
        gport = (ne[0] && ne[1]) ? ~last_grant : ~ne[0];
        pop   = 2'b00;
        if (grant) begin
            pop[gport] = 1'b1;
        end
    end

    always_comb begin
        fpc_in_valid = grant;
        fpc_mode     = 1'b0;
        fpc_in_a     = 16'h0000;
        fpc_in_b     = 16'h0000;
        if (grant) begin
            {fpc_mode, fpc_in_a, fpc_in_b} = head[gport];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            tag_v      <= 1'b0;
            tag        <= 1'b0;
        end else begin
            tag_v <= grant;
            tag   <= gport;
            if (grant) begin
                last_grant <= gport;
            end
        end
    end

    assign rsp_valid[0] = fpc_out_valid && tag_v && !tag;
    assign rsp_valid[1] = fpc_out_valid && tag_v && tag;
    assign rsp_data     = fpc_out;
    assign fpc_rst_n    = ~rst;
    assign busy         = (count[0] != '0) || (count[1] != '0) || tag_v;

endmodule

`default_nettype wire
